// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked multi-cycle data memory with byte/half/word lanes, extension and fault reporting
module data_mem_responder #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [1:0]            req_maskmode,
  input  logic                  req_zext,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state_q;
  logic [3:0] cnt_q, be;
  logic wr_q, zext_q, ready_q, valid_q, err_q, err_d, wr, zext, enter;
  logic [1:0] mode_q, mode;
  logic [31:0] addr_q, wdata_q, rdata_q, rdata_d, addr, wdata, word, shifted, lanes;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0] mem [2**DEPTH_LOG2];
  assign req_ready  = ready_q;
  assign resp_valid = valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  // With zero latency the commit lands on the accept edge, so IDLE uses the live request.
  always_comb begin
    wr      = state_q == IDLE ? req_write : wr_q;
    zext    = state_q == IDLE ? req_zext : zext_q;
    mode    = state_q == IDLE ? req_maskmode : mode_q;
    addr    = state_q == IDLE ? req_addr : addr_q;
    wdata   = state_q == IDLE ? req_wdata : wdata_q;
    enter   = state_q == IDLE ? req_valid && LATENCY == 0 : state_q == BUSY && cnt_q == 4'd1;
    idx     = addr[DEPTH_LOG2+1:2];
    err_d   = mode == 2'b11 || (mode == 2'b01 && addr[0]) || (mode == 2'b10 && addr[1:0] != 2'b00) ||
              addr[31:DEPTH_LOG2+2] != '0;
    be      = mode == 2'b00 ? 4'b0001 << addr[1:0] : mode == 2'b01 ? 4'b0011 << {addr[1], 1'b0} : 4'b1111;
    lanes   = mode == 2'b00 ? {4{wdata[7:0]}} : mode == 2'b01 ? {2{wdata[15:0]}} : wdata;
    word    = mem[idx];
    shifted = word >> {addr[1:0], 3'b000};
    rdata_d = (err_d || wr) ? '0 :
              mode == 2'b00 ? {{24{~zext & shifted[7]}}, shifted[7:0]} :
              mode == 2'b01 ? {{16{~zext & shifted[15]}}, shifted[15:0]} : word;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        mode_q  <= req_maskmode;
        zext_q  <= req_zext;
        cnt_q   <= 4'(LATENCY);
        ready_q <= 1'b0;
        state_q <= LATENCY == 0 ? RESP : BUSY;
      end else if (state_q == BUSY) begin
        cnt_q <= cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_q <= RESP;
      end else if (state_q == RESP && resp_ready) begin
        state_q <= IDLE;
        valid_q <= 1'b0;
        ready_q <= 1'b1;
      end
      if (enter) begin
        valid_q <= 1'b1;
        rdata_q <= rdata_d;
        err_q   <= err_d;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && enter && wr && !err_d)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= lanes[8*i +: 8];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed plus random load/store traffic checked against a byte-array reference
module tb_data_mem_responder;
  localparam int LAT = 2;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, req_write = 1'b0, req_zext = 1'b0, resp_ready = 1'b0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic [1:0] req_maskmode = '0;
  logic [7:0] mem_m [4096];
  int n_chk = 0, n_fail = 0;
  logic [31:0] got_rd;
  logic got_err;

  always #5 clk = ~clk;

  data_mem_responder #(.DATA_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_maskmode(req_maskmode), .req_zext(req_zext),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: memory as a flat byte array, access width in bytes, natural alignment.
  function automatic void model(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] m,
                                input bit z, output logic [31:0] rd, output bit e);
    int n;
    n  = m == 2'd0 ? 1 : m == 2'd1 ? 2 : 4;
    e  = m == 2'd3 || (a % n) != 0 || a >= 32'd4096;
    rd = '0;
    if (!e) begin
      if (w) for (int i = 0; i < n; i++) mem_m[a + i] = wd[8*i +: 8];
      else begin
        for (int i = 0; i < n; i++) rd[8*i +: 8] = mem_m[a + i];
        if (!z && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8*n));
      end
    end
  endfunction

  task automatic scramble();
    req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    req_maskmode = 2'($urandom); req_zext = 1'($urandom);
  endtask

  task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] wd, input logic [1:0] m,
                      input bit z, input int hold, input string tag);
    logic [31:0] erd;
    bit ee;
    int n;
    model(w, a, wd, m, z, erd, ee);
    n = 0;
    while (!req_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_maskmode = m; req_zext = z;
    @(posedge clk); #1;
    req_valid = 1'($urandom);
    scramble();
    n = 1;
    while (!resp_valid && n < 40) begin
      chk({tag, " req_ready busy"}, 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      scramble();
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(LAT + 1));
    for (int i = 0; i <= hold; i++) begin
      chk({tag, " rdata"}, resp_rdata, erd);
      chk({tag, " err"}, 32'(resp_err), 32'(ee));
      chk({tag, " valid held"}, 32'(resp_valid), 32'd1);
      chk({tag, " req_ready resp"}, 32'(req_ready), 32'd0);
      if (i < hold) begin @(posedge clk); #1; end
    end
    got_rd = resp_rdata;
    got_err = resp_err;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk({tag, " valid drop"}, 32'(resp_valid), 32'd0);
    chk({tag, " req_ready back"}, 32'(req_ready), 32'd1);
  endtask

  // Accepts SW 0x55 @0x20 and asserts rst so it is sampled `edges` edges after the accept edge.
  task automatic abort_sw(input int edges);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55; req_maskmode = 2'd2; req_zext = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (edges - 1) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort valid", 32'(resp_valid), 32'd0);
    chk("abort ready", 32'(req_ready), 32'd1);
    chk("abort rdata", resp_rdata, 32'd0);
    chk("abort err", 32'(resp_err), 32'd0);
    repeat (LAT + 3) begin
      @(posedge clk); #1;
      chk("abort no response", 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 64; i++) xact(1'b1, 32'(i * 4), $urandom, 2'd2, 1'b0, 0, "init");
    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 2'd2, 1'b0, 0, "sw10");
    xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "lw10");
    chk("lw10 value", got_rd, 32'hDEAD_BEEF);
    chk("lw10 noerr", 32'(got_err), 32'd0);
    xact(1'b1, 32'h13, 32'h80, 2'd0, 1'b0, 0, "sb13");
    xact(1'b0, 32'h13, 32'h0, 2'd0, 1'b0, 1, "lb13");
    chk("lb13 value", got_rd, 32'hFFFF_FF80);
    xact(1'b0, 32'h13, 32'h0, 2'd0, 1'b1, 0, "lbu13");
    chk("lbu13 value", got_rd, 32'h0000_0080);
    xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b1, 0, "lw10b");
    chk("lw10b value", got_rd, 32'h80AD_BEEF);
    xact(1'b1, 32'h12, 32'h1234, 2'd1, 1'b0, 0, "sh12");
    xact(1'b0, 32'h12, 32'h0, 2'd1, 1'b0, 0, "lh12");
    chk("lh12 value", got_rd, 32'h0000_1234);
    xact(1'b0, 32'h11, 32'h0, 2'd1, 1'b0, 0, "lh11");
    chk("lh11 err", 32'(got_err), 32'd1);
    chk("lh11 rdata", got_rd, 32'd0);
    xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 0, "lw10c");
    chk("lw10c value", got_rd, 32'h1234_BEEF);
    xact(1'b1, 32'h1002, 32'hCAFE_F00D, 2'd2, 1'b0, 0, "sw1002");
    chk("sw1002 err", 32'(got_err), 32'd1);
    xact(1'b0, 32'h1000, 32'h0, 2'd2, 1'b0, 0, "lw1000");
    chk("lw1000 err", 32'(got_err), 32'd1);
    xact(1'b1, 32'h12, 32'hCAFE_F00D, 2'd2, 1'b0, 0, "sw12 misaligned");
    xact(1'b1, 32'h10, 32'hCAFE_F00D, 2'd3, 1'b0, 0, "store reserved");
    chk("store reserved err", 32'(got_err), 32'd1);
    xact(1'b0, 32'h0, 32'h0, 2'd2, 1'b0, 0, "lw0 untouched");
    xact(1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 5, "lw10 hold");
    chk("lw10 hold value", got_rd, 32'h1234_BEEF);
    abort_sw(1);
    xact(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, "lw20 after busy abort");
    abort_sw(LAT);
    xact(1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 0, "lw20 after commit abort");
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = $urandom_range(0, 1) ? 32'h1000 + a : $urandom;
      xact(1'($urandom), a, $urandom, 2'($urandom_range(0, 3)), 1'($urandom), $urandom_range(0, 3), "random");
    end
    for (int i = 0; i < 64; i++) xact(1'b0, 32'(i * 4), 32'h0, 2'd2, 1'b0, 0, "final sweep");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
